// File: rtl/stream_pkg.sv
// -----------------------------------------------------------------------------
// stream_pkg: shared types and helpers for the stream width converters.
//   cnt_width(ratio) : bits needed to hold a beat count in 0..ratio
//   PACK_MAX_RATIO   : largest supported beats-per-word ratio
//   pack_count_t     : beat count type wide enough for PACK_MAX_RATIO
// -----------------------------------------------------------------------------
package stream_pkg;

    localparam int unsigned PACK_MAX_RATIO = 16;

    // Width of a counter that must represent 0..ratio inclusive.
    function automatic int unsigned cnt_width(input int unsigned ratio);
        return $clog2(ratio + 1);
    endfunction

    typedef logic [$clog2(PACK_MAX_RATIO + 1)-1:0] pack_count_t;

endpackage : stream_pkg

// File: rtl/pack_out_reg.sv
// -----------------------------------------------------------------------------
// pack_out_reg: wide output holding register with valid/ready handshake.
//   clk, rst : clock, asynchronous active-high reset
//   load_i   : capture data_i and raise valid on this edge
//   data_i   : word to capture
//   ready_i  : downstream accepts the held word
//   valid_o  : held word is valid (registered)
//   data_o   : held word (registered)
// A load has priority over a drain, so a word leaving and a new word
// arriving in the same cycle keeps valid_o high without a bubble.
// The caller must only assert load_i when the register is free or draining.
// -----------------------------------------------------------------------------
module pack_out_reg
    import stream_pkg::*;
#(
    parameter int unsigned W = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q,  data_d;

    // Next-state: load wins over drain.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule : pack_out_reg

// File: rtl/stream_packer.sv
// -----------------------------------------------------------------------------
// stream_packer: gathers RATIO narrow valid/ready beats into one registered
// WIDTH*RATIO-bit word, little-endian lane order (beat k -> lane k).
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : upstream beat valid
//   in_ready   : packer accepts a beat this cycle (combinational on out_ready)
//   in_data    : upstream beat payload
//   out_valid  : packed word valid (registered)
//   out_ready  : downstream accepts the packed word
//   out_data   : packed word (registered)
//   flush      : PACKER_FLUSH_EN only; emit the partial word
//   out_count  : PACKER_FLUSH_EN only; number of valid lanes in out_data
// Optional feature macro: PACKER_FLUSH_EN.
// -----------------------------------------------------------------------------
module stream_packer
    import stream_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned RATIO = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH*RATIO-1:0]        out_data
`ifdef PACKER_FLUSH_EN
    ,
    input  logic                          flush,
    output logic [cnt_width(RATIO)-1:0]   out_count
`endif
);

    localparam int unsigned OUT_W  = WIDTH * RATIO;
    localparam int unsigned CNT_W  = $clog2(RATIO);
    localparam int unsigned OCNT_W = cnt_width(RATIO);

    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [RATIO-2:0][WIDTH-1:0]   acc_q, acc_d;

    logic             last_slot;
    logic             out_free;
    logic             in_fire;
    logic             complete;
    logic             load;
    logic [OUT_W-1:0] load_data;

    assign last_slot = (cnt_q == CNT_W'(RATIO - 1));
    assign out_free  = !out_valid || out_ready;

`ifdef PACKER_FLUSH_EN
    logic              flush_pending_q, flush_pending_d;
    logic              flush_load;
    logic [OCNT_W-1:0] out_count_q, out_count_d;
    logic [OUT_W-1:0]  partial_word;

    // Only the completing beat waits for the output; a pending flush blocks all.
    assign in_ready   = (!last_slot || out_free) && !flush_pending_q;
    assign flush_load = flush_pending_q && out_free;
`else
    // Only the completing beat waits for the output register to free.
    assign in_ready = !last_slot || out_free;
`endif

    assign in_fire  = in_valid && in_ready;
    assign complete = in_fire && last_slot;

    // Slot counter and assembly array.
    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        if (in_fire) begin
            if (last_slot) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                for (int k = 0; k < int'(RATIO) - 1; k++) begin
                    if (cnt_q == CNT_W'(k)) begin
                        acc_d[k] = in_data;
                    end
                end
            end
        end
`ifdef PACKER_FLUSH_EN
        // in_ready is low while flushing, so this never collides with in_fire.
        if (flush_load) begin
            cnt_d = '0;
        end
`endif
    end

`ifdef PACKER_FLUSH_EN
    // Flush request: needs at least one gathered beat after this cycle.
    // A beat that completes the word already emits it in full, so the flush
    // is dropped rather than producing an empty word.
    always_comb begin
        flush_pending_d = flush_pending_q;
        if (flush_load) begin
            flush_pending_d = 1'b0;
        end else if (flush && !flush_pending_q && !complete &&
                     ((cnt_q != '0) || in_fire)) begin
            flush_pending_d = 1'b1;
        end
    end

    // Partial word: lanes below cnt carry data, the rest read as zero.
    always_comb begin
        partial_word = '0;
        for (int k = 0; k < int'(RATIO) - 1; k++) begin
            if (CNT_W'(k) < cnt_q) begin
                partial_word[k*WIDTH +: WIDTH] = acc_q[k];
            end
        end
    end

    // Beat count travelling with the held word.
    always_comb begin
        out_count_d = out_count_q;
        if (complete) begin
            out_count_d = OCNT_W'(RATIO);
        end else if (flush_load) begin
            out_count_d = OCNT_W'(cnt_q);
        end
    end

    assign load      = complete || flush_load;
    assign load_data = flush_load ? partial_word : {in_data, acc_q};
    assign out_count = out_count_q;
`else
    assign load      = complete;
    assign load_data = {in_data, acc_q};
`endif

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

`ifdef PACKER_FLUSH_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_pending_q <= 1'b0;
            out_count_q     <= '0;
        end else begin
            flush_pending_q <= flush_pending_d;
            out_count_q     <= out_count_d;
        end
    end
`endif

    pack_out_reg #(
        .W (OUT_W)
    ) u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .data_i  (load_data),
        .ready_i (out_ready),
        .valid_o (out_valid),
        .data_o  (out_data)
    );

endmodule : stream_packer

// File: tb/tb_stream_packer.sv
// -----------------------------------------------------------------------------
// tb_stream_packer: directed bench for stream_packer (WIDTH=32, RATIO=4).
// Inputs change 1 ns after the rising edge; outputs are sampled 1-2 ns after.
// Flush scenarios are built only when PACKER_FLUSH_EN is defined.
// -----------------------------------------------------------------------------
module tb_stream_packer;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned RATIO = 4;
    localparam int unsigned OUT_W = WIDTH * RATIO;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic               out_valid;
    logic               out_ready;
    logic [OUT_W-1:0]   out_data;
`ifdef PACKER_FLUSH_EN
    logic               flush;
    logic [2:0]         out_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    stream_packer #(
        .WIDTH (WIDTH),
        .RATIO (RATIO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PACKER_FLUSH_EN
        ,
        .flush     (flush),
        .out_count (out_count)
`endif
    );

    task automatic check(input string tag, input logic [OUT_W-1:0] got,
                         input logic [OUT_W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [WIDTH-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
    endtask

    function automatic logic [OUT_W-1:0] word4(input logic [WIDTH-1:0] l0,
                                              input logic [WIDTH-1:0] l1,
                                              input logic [WIDTH-1:0] l2,
                                              input logic [WIDTH-1:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
`ifdef PACKER_FLUSH_EN
        flush     = 1'b0;
`endif

        // Reset state.
        #12;
        check("rst_vld", out_valid, 0);
        check("rst_data", out_data, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("rel_vld", out_valid, 0);
        check("rel_rdy", in_ready, 1);

        // Basic group of four.
        beat(32'h11);
        beat(32'h22);
        beat(32'h33);
        in_valid = 1'b1;
        in_data  = 32'h44;
        #1;
        check("a_rdy_last", in_ready, 1);
        check("a_vld_pre", out_valid, 0);
        tick();
        in_valid = 1'b0;
        check("a_vld", out_valid, 1);
        check("a_data", out_data, 128'h00000044_00000033_00000022_00000011);
`ifdef PACKER_FLUSH_EN
        check("a_count", out_count, 3'd4);
`endif
        tick();
        check("a_drain", out_valid, 0);

        // Sixteen back-to-back beats: a word every fourth cycle, no stalls.
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(32'h100 + i);
            #1;
            check("b_rdy", in_ready, 1);
            tick();
            check("b_vld", out_valid, (i % 4) == 3);
            if ((i % 4) == 3) begin
                check("b_word", out_data,
                      word4(32'(32'h100 + i - 3), 32'(32'h100 + i - 2),
                            32'(32'h100 + i - 1), 32'(32'h100 + i)));
            end
        end
        in_valid = 1'b0;
        tick();
        check("b_drain", out_valid, 0);

        // Output stall: three beats keep filling, the fourth waits.
        beat(32'hA0);
        beat(32'hA1);
        beat(32'hA2);
        beat(32'hA3);
        out_ready = 1'b0;
        check("c_w1_vld", out_valid, 1);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(32'hB0 + i);
            #1;
            check("c_rdy_fill", in_ready, 1);
            tick();
        end
        in_data = 32'hB3;
        #1;
        check("c_rdy_block", in_ready, 0);
        tick();
        check("c_hold_vld", out_valid, 1);
        check("c_hold_data", out_data, word4(32'hA0, 32'hA1, 32'hA2, 32'hA3));
        check("c_rdy_still", in_ready, 0);
        out_ready = 1'b1;
        #1;
        check("c_rdy_free", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("c_w2_vld", out_valid, 1);
        check("c_w2_data", out_data, word4(32'hB0, 32'hB1, 32'hB2, 32'hB3));
        tick();
        check("c_drain", out_valid, 0);

        // Reset mid-group with a held word: everything clears at once.
        out_ready = 1'b0;
        beat(32'hD0);
        beat(32'hD1);
        beat(32'hD2);
        beat(32'hD3);
        check("d_held", out_valid, 1);
        beat(32'hE0);
        beat(32'hE1);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("d_async_vld", out_valid, 0);
        check("d_async_data", out_data, 0);
        #1;
        rst = 1'b0;
        tick();
        out_ready = 1'b1;
        beat(32'hF0);
        beat(32'hF1);
        check("d_no_early", out_valid, 0);
        beat(32'hF2);
        beat(32'hF3);
        in_valid = 1'b0;
        check("d_vld", out_valid, 1);
        check("d_clean", out_data, word4(32'hF0, 32'hF1, 32'hF2, 32'hF3));
        tick();

`ifdef PACKER_FLUSH_EN
        // Flush after three beats.
        beat(32'hA);
        beat(32'hB);
        beat(32'hC);
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush = 1'b0;
        check("e_pend_vld", out_valid, 0);
        in_valid = 1'b1;
        in_data  = 32'h99;
        #1;
        check("e_pend_rdy", in_ready, 0);
        in_valid = 1'b0;
        tick();
        check("e_vld", out_valid, 1);
        check("e_data", out_data, word4(32'hA, 32'hB, 32'hC, 32'h0));
        check("e_count", out_count, 3'd3);
        tick();
        check("e_drain", out_valid, 0);

        // Flush with nothing gathered is ignored.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("e_empty_rdy", in_ready, 1);
        tick();
        check("e_empty_vld1", out_valid, 0);
        tick();
        check("e_empty_vld2", out_valid, 0);

        // Flush behind a stalled word.
        out_ready = 1'b0;
        beat(32'hC0);
        beat(32'hC1);
        beat(32'hC2);
        beat(32'hC3);
        beat(32'hD0);
        beat(32'hD1);
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'hDEAD;
        #1;
        check("f_rdy_pend", in_ready, 0);
        tick();
        check("f_hold_vld", out_valid, 1);
        check("f_hold_data", out_data, word4(32'hC0, 32'hC1, 32'hC2, 32'hC3));
        check("f_hold_cnt", out_count, 3'd4);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("f_rdy_drain", in_ready, 0);
        tick();
        check("f_vld", out_valid, 1);
        check("f_data", out_data, word4(32'hD0, 32'hD1, 32'h0, 32'h0));
        check("f_count", out_count, 3'd2);
        check("f_rdy_after", in_ready, 1);
        tick();
        check("f_drain", out_valid, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_stream_packer
